// File: rtl/cpu_pkg.sv
// Shared types for the effective-address sequencer: addressing modes, FSM
// states and the default zero-page high byte.
package cpu_pkg;

  typedef enum logic [1:0] {
    ABS_IDX       = 2'b00,
    ZP_IDX        = 2'b01,
    REL           = 2'b10,
    ABS_IDX_FORCE = 2'b11
  } addr_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } ea_state_t;

  localparam logic [7:0] ZP_PAGE_DEF = 8'h00;

endpackage

// File: rtl/ea_page_add.sv
// 8-bit low-byte adder with carry-out decoded into a high-byte inc/dec request.
module ea_page_add
  import cpu_pkg::*;
(
  input  logic [7:0] base_l,
  input  logic [7:0] operand,
  input  addr_mode_t mode,
  output logic [7:0] sum,
  output logic       cross_inc,
  output logic       cross_dec
);

  logic [8:0] sum9;

  always_comb begin
    sum9      = {1'b0, base_l} + {1'b0, operand};
    sum       = sum9[7:0];
    cross_inc = 1'b0;
    cross_dec = 1'b0;
    case (mode)
      ABS_IDX, ABS_IDX_FORCE: cross_inc = sum9[8];
      // Signed offset: carry with a positive offset crosses up, no carry with a
      // negative offset crosses down.
      REL: begin
        cross_inc = ~operand[7] & sum9[8];
        cross_dec = operand[7] & ~sum9[8];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ea_fixup_unit.sv
// Effective-address sequencer: loads low/provisional high byte, then fixes the
// high byte with an inc/dec strobe one cycle later on a page crossing.
module ea_fixup_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0] ZP_PAGE = ZP_PAGE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] base_l,
  input  logic [7:0] base_h,
  input  logic [7:0] operand,
  output logic       ld_l_o,
  output logic       ld_h_o,
  output logic [7:0] l_o,
  output logic [7:0] h_o,
  output logic       h_inc_o,
  output logic       h_dec_o,
  output logic       busy,
  output logic       done,
  output logic       page_cross
);

  ea_state_t  state_q, state_d;
  addr_mode_t mode_q, mode_d;
  logic [7:0] base_l_q, base_l_d;
  logic [7:0] base_h_q, base_h_d;
  logic [7:0] operand_q, operand_d;
  logic       inc_q, inc_d;
  logic       dec_q, dec_d;

  logic [7:0] sum;
  logic       cross_inc, cross_dec;

  // Adder works only on latched values, so no input reaches an output.
  ea_page_add u_add (
    .base_l   (base_l_q),
    .operand  (operand_q),
    .mode     (mode_q),
    .sum      (sum),
    .cross_inc(cross_inc),
    .cross_dec(cross_dec)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    base_l_d   = base_l_q;
    base_h_d   = base_h_q;
    operand_d  = operand_q;
    inc_d      = inc_q;
    dec_d      = dec_q;
    ld_l_o     = 1'b0;
    ld_h_o     = 1'b0;
    l_o        = 8'h00;
    h_o        = 8'h00;
    h_inc_o    = 1'b0;
    h_dec_o    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    page_cross = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d    = addr_mode_t'(mode);
          base_l_d  = base_l;
          base_h_d  = base_h;
          operand_d = operand;
          inc_d     = 1'b0;
          dec_d     = 1'b0;
          state_d   = ADD;
        end
      end
      ADD: begin
        busy    = 1'b1;
        ld_l_o  = 1'b1;
        ld_h_o  = 1'b1;
        l_o     = sum;
        h_o     = (mode_q == ZP_IDX) ? ZP_PAGE : base_h_q;
        inc_d   = cross_inc;
        dec_d   = cross_dec;
        // Store/RMW indexed always spends the fix-up cycle, crossing or not.
        state_d = (cross_inc || cross_dec || mode_q == ABS_IDX_FORCE) ? FIX : DONE;
      end
      FIX: begin
        busy    = 1'b1;
        h_inc_o = inc_q;
        h_dec_o = dec_q;
        state_d = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        page_cross = inc_q | dec_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= ABS_IDX;
      base_l_q  <= 8'h00;
      base_h_q  <= 8'h00;
      operand_q <= 8'h00;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      base_l_q  <= base_l_d;
      base_h_q  <= base_h_d;
      operand_q <= operand_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
    end
  end

endmodule

// File: tb/tb_ea_fixup_unit.sv
// Bench for ea_fixup_unit: vector table feeding a scoreboard queue, a negedge
// monitor that models the PC register block, plus abort and held-start cases.
module tb_ea_fixup_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] base_l = 8'h00, base_h = 8'h00, operand = 8'h00;
  logic       ld_l_o, ld_h_o, h_inc_o, h_dec_o, busy, done, page_cross;
  logic [7:0] l_o, h_o;

  ea_fixup_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .base_l(base_l), .base_h(base_h), .operand(operand),
    .ld_l_o(ld_l_o), .ld_h_o(ld_h_o), .l_o(l_o), .h_o(h_o),
    .h_inc_o(h_inc_o), .h_dec_o(h_dec_o), .busy(busy), .done(done),
    .page_cross(page_cross)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  bl, bh, op;
    logic [7:0]  l, h;
    int          ninc, ndec;
    logic        pc;
    int          lat;
    logic [15:0] regv;
  } vec_t;

  vec_t vecs[11];
  vec_t q[$];

  int total = 0, bad = 0;
  int cyc = 0, acc_cyc = 0, n_acc = 0, n_done = 0, n_inc_tot = 0;
  int n_ld = 0, n_inc = 0, n_dec = 0, overlap = 0;
  logic [7:0]  cap_l = 8'h00, cap_h = 8'h00;
  logic [15:0] regm = 16'h0000;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Register-block model and per-operation observation
  always @(negedge clk) begin
    vec_t e;
    if (rst_n && !busy && start) begin
      acc_cyc = cyc + 1;
      n_acc++;
      n_ld = 0; n_inc = 0; n_dec = 0; overlap = 0;
    end
    if ((ld_l_o || ld_h_o) && (h_inc_o || h_dec_o)) overlap++;
    if (ld_l_o) begin n_ld++; cap_l = l_o; regm[7:0] = l_o; end
    if (ld_h_o) begin cap_h = h_o; regm[15:8] = h_o; end
    if (h_inc_o) begin regm[15:8] = regm[15:8] + 8'd1; n_inc++; n_inc_tot++; end
    if (h_dec_o) begin regm[15:8] = regm[15:8] - 8'd1; n_dec++; end
    if (done) begin
      n_done++;
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 want no completion (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        chk("l_o", cap_l, e.l);
        chk("h_o", cap_h, e.h);
        chk("ld_count", n_ld, 1);
        chk("inc_count", n_inc, e.ninc);
        chk("dec_count", n_dec, e.ndec);
        chk("page_cross", page_cross, e.pc);
        chk("latency", cyc - acc_cyc + 1, e.lat);
        chk("register", regm, e.regv);
        chk("strobe_overlap", overlap, 0);
      end
    end
  end

  task automatic wait_empty(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic drive(input vec_t v);
    mode = v.mode; base_l = v.bl; base_h = v.bh; operand = v.op;
  endtask

  initial begin
    int a0, i0, d0;
    //            mode   bl     bh     op     l      h     inc dec pc  lat reg
    vecs[0]  = '{2'b00, 8'hF0, 8'h12, 8'h05, 8'hF5, 8'h12, 0, 0, 1'b0, 2, 16'h12F5};
    vecs[1]  = '{2'b00, 8'hF0, 8'h12, 8'h20, 8'h10, 8'h12, 1, 0, 1'b1, 3, 16'h1310};
    vecs[2]  = '{2'b10, 8'h05, 8'h20, 8'hF0, 8'hF5, 8'h20, 0, 1, 1'b1, 3, 16'h1FF5};
    vecs[3]  = '{2'b10, 8'hF0, 8'h20, 8'h7F, 8'h6F, 8'h20, 1, 0, 1'b1, 3, 16'h216F};
    vecs[4]  = '{2'b10, 8'h80, 8'h20, 8'h10, 8'h90, 8'h20, 0, 0, 1'b0, 2, 16'h2090};
    vecs[5]  = '{2'b01, 8'hF0, 8'h55, 8'h20, 8'h10, 8'h00, 0, 0, 1'b0, 2, 16'h0010};
    vecs[6]  = '{2'b11, 8'h00, 8'h12, 8'h01, 8'h01, 8'h12, 0, 0, 1'b0, 3, 16'h1201};
    vecs[7]  = '{2'b00, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'hFF, 1, 0, 1'b1, 3, 16'h0000};
    vecs[8]  = '{2'b10, 8'h10, 8'h20, 8'hF0, 8'h00, 8'h20, 0, 0, 1'b0, 2, 16'h2000};
    vecs[9]  = '{2'b11, 8'hF0, 8'h12, 8'h20, 8'h10, 8'h12, 1, 0, 1'b1, 3, 16'h1310};
    vecs[10] = '{2'b10, 8'hFF, 8'h20, 8'h01, 8'h00, 8'h20, 1, 0, 1'b1, 3, 16'h2100};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {ld_l_o, ld_h_o, l_o, h_o, h_inc_o, h_dec_o, busy, done, page_cross}, 0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(posedge clk); #1;
      drive(vecs[k]);
      start = 1'b1;
      q.push_back(vecs[k]);
      @(posedge clk); #1;
      start = 1'b0;
      wait_empty(20);
    end

    // start held through a whole operation: exactly one re-accept after DONE
    a0 = n_acc;
    @(posedge clk); #1;
    drive(vecs[6]);
    start = 1'b1;
    q.push_back(vecs[6]);
    q.push_back(vecs[6]);
    wait_empty(30);
    start = 1'b0;
    repeat (4) @(posedge clk);
    chk("held_start_accepts", n_acc - a0, 2);

    // reset asserted at the edge that would enter FIX aborts the crossing op
    @(posedge clk); #1;
    drive(vecs[1]);
    i0 = n_inc_tot; d0 = n_done;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_outputs", {ld_l_o, ld_h_o, l_o, h_o, h_inc_o, h_dec_o, busy, done, page_cross}, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_inc", n_inc_tot - i0, 0);
    chk("abort_no_done", n_done - d0, 0);

    @(posedge clk); #1;
    drive(vecs[1]);
    start = 1'b1;
    q.push_back(vecs[1]);
    @(posedge clk); #1;
    start = 1'b0;
    wait_empty(20);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
